// File: rtl/uart_reg_master.sv
// Register-bus initiator for the UART register file: enables the UART, polls CON, moves bytes between RXD/TXD and two valid/ready byte streams.
// Optional loopback: define UART_ECHO_EN to copy each received byte into the tx holding register when it is empty.
module uart_reg_master #(
   parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
   parameter int unsigned POLL_GAP   = 4,
   parameter logic [19:0] TX_TIMEOUT = 20'd200000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        rd,
   output logic        wr,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   input  logic [31:0] rdata,
   input  logic [7:0]  tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic        tx_busy,
   output logic        tx_timeout
);

   localparam logic [31:0] ADDR_TXD = BASE_ADDR + 32'h18;
   localparam logic [31:0] ADDR_RXD = BASE_ADDR + 32'h1C;
   localparam logic [31:0] ADDR_CON = BASE_ADDR + 32'h20;
   localparam logic [7:0]  GAP_LAST = 8'(POLL_GAP - 1);

   typedef enum logic [2:0] {
      S_INIT, S_GAP, S_POLL, S_DECIDE, S_RD_RX, S_WR_TX, S_ACK_TX
   } state_t;

   state_t      state_q, state_d;
   logic        rd_q, rd_d, wr_q, wr_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
   logic [7:0]  gap_q, gap_d;
   logic [2:0]  con_q, con_d;      // CON[4:2]
   logic [7:0]  rx_data_q, rx_data_d;
   logic        rx_valid_q, rx_valid_d;
   logic [7:0]  hold_q, hold_d;
   logic        hold_full_q, hold_full_d;
   logic        tx_busy_q, tx_busy_d;
   logic [19:0] tmo_q, tmo_d;
   logic        tmo_flag_q, tmo_flag_d;
   logic        tx_ready_w;
   logic        unused_rdata;

   assign unused_rdata = ^{rdata[31:8], rdata[1:0]};

`ifdef UART_ECHO_EN
   // The echo load owns the holding register during the RXD read.
   assign tx_ready_w = !hold_full_q && (state_q != S_RD_RX);
`else
   assign tx_ready_w = !hold_full_q;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_INIT;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         gap_q       <= '0;
         con_q       <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         tx_busy_q   <= 1'b0;
         tmo_q       <= '0;
         tmo_flag_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         gap_q       <= gap_d;
         con_q       <= con_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         tx_busy_q   <= tx_busy_d;
         tmo_q       <= tmo_d;
         tmo_flag_q  <= tmo_flag_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      rd_d        = 1'b0;
      wr_d        = 1'b0;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      gap_d       = '0;
      con_d       = con_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      tx_busy_d   = tx_busy_q;
      tmo_d       = tmo_q;
      tmo_flag_d  = tmo_flag_q;

      if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
      if (tx_valid && tx_ready_w) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end
      if (tx_busy_q) begin
         if (tmo_q == TX_TIMEOUT - 20'd1) begin
            tmo_flag_d = 1'b1;
            tx_busy_d  = 1'b0;
         end else begin
            tmo_d = tmo_q + 20'd1;
         end
      end

      case (state_q)
         // INIT holds one extra cycle after reset so its write strobe can be registered.
         S_INIT:   if (wr_q) state_d = S_GAP;
         S_GAP: begin
            gap_d = gap_q + 8'd1;
            if (gap_q == GAP_LAST) state_d = S_POLL;
         end
         S_POLL: begin
            con_d   = rdata[4:2];
            state_d = S_DECIDE;
         end
         S_DECIDE: begin
            if (con_q[1] && !rx_valid_q)                  state_d = S_RD_RX;
            else if (tx_busy_q && con_q[0] && !con_q[2])  state_d = S_ACK_TX;
            else if (hold_full_q && !tx_busy_q)           state_d = S_WR_TX;
            else                                          state_d = S_GAP;
         end
         S_RD_RX: begin
            rx_data_d  = rdata[7:0];
            rx_valid_d = 1'b1;
`ifdef UART_ECHO_EN
            if (!hold_full_q) begin
               hold_d      = rdata[7:0];
               hold_full_d = 1'b1;
            end
`endif
            state_d = S_GAP;
         end
         S_WR_TX: begin
            hold_full_d = 1'b0;
            tx_busy_d   = 1'b1;
            tmo_d       = '0;
            state_d     = S_GAP;
         end
         S_ACK_TX: begin
            tx_busy_d = 1'b0;
            state_d   = S_GAP;
         end
         default:  state_d = S_INIT;
      endcase

      // Bus strobes are registered from the state being entered.
      case (state_d)
         S_INIT:   begin wr_d = 1'b1; addr_d = ADDR_CON; wdata_d = 32'h3; end
         S_POLL:   begin rd_d = 1'b1; addr_d = ADDR_CON; end
         S_RD_RX:  begin rd_d = 1'b1; addr_d = ADDR_RXD; end
         S_WR_TX:  begin wr_d = 1'b1; addr_d = ADDR_TXD; wdata_d = {24'b0, hold_q}; end
         S_ACK_TX: begin rd_d = 1'b1; addr_d = ADDR_TXD; end
         default:  ;
      endcase
   end

   assign rd         = rd_q;
   assign wr         = wr_q;
   assign addr       = addr_q;
   assign wdata      = wdata_q;
   assign tx_ready   = tx_ready_w;
   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign tx_busy    = tx_busy_q;
   assign tx_timeout = tmo_flag_q;

endmodule

// File: tb/tb_uart_reg_master.sv
// Bench for uart_reg_master with a small UART register-file model; exercises the echo path when UART_ECHO_EN is defined.
module tb_uart_reg_master;

   localparam int          POLL_GAP = 4;
   localparam logic [31:0] A_TXD    = 32'h4000_0018;
   localparam logic [31:0] A_RXD    = 32'h4000_001C;
   localparam logic [31:0] A_CON    = 32'h4000_0020;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd, wr;
   logic [31:0] addr, wdata, rdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        tx_busy;
   logic        tx_timeout;

   always #5 clk = ~clk;

   uart_reg_master #(
      .BASE_ADDR (32'h4000_0000),
      .POLL_GAP  (POLL_GAP),
      .TX_TIMEOUT(20'd100)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rd        (rd),
      .wr        (wr),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .tx_busy   (tx_busy),
      .tx_timeout(tx_timeout)
   );

   // UART register model: status bits are set by the stimulus, cleared by the matching read.
   int          rx_set_cnt = 0, rx_rd_cnt = 0;
   int          tx_set_cnt = 0, tx_ack_cnt = 0;
   int          poll_cnt = 0, both_cnt = 0;
   logic [7:0]  rxd_val = 8'h00;
   logic        con2, con3;

   assign con3 = (rx_set_cnt != rx_rd_cnt);
   assign con2 = (tx_set_cnt != tx_ack_cnt);

   always_comb begin
      rdata = '0;
      if (rd) begin
         if (addr == A_CON)      rdata = {27'b0, 1'b0, con3, con2, 2'b11};
         else if (addr == A_RXD) rdata = {24'b0, rxd_val};
      end
   end

   always @(posedge clk) begin
      if (rd && wr)                     both_cnt   <= both_cnt + 1;
      if (rd && addr == A_CON)          poll_cnt   <= poll_cnt + 1;
      if (rd && addr == A_RXD && con3)  rx_rd_cnt  <= rx_set_cnt;
      if (rd && addr == A_TXD && con2)  tx_ack_cnt <= tx_set_cnt;
   end

   int n_chk = 0, n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_rng(input string name, input int act, input int lo, input int hi);
      n_chk++;
      if (act < lo || act > hi) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Next bus access other than a CON poll, bounded by a cycle budget.
   logic        acc_ok, acc_rd, acc_wr;
   logic [31:0] acc_addr, acc_wdata;
   int          acc_cyc;

   task automatic wait_acc(input string name, input int budget);
      acc_ok = 1'b0; acc_rd = 1'b0; acc_wr = 1'b0;
      acc_addr = '0; acc_wdata = '0; acc_cyc = budget;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         if ((rd || wr) && !(rd && addr == A_CON)) begin
            acc_ok = 1'b1; acc_rd = rd; acc_wr = wr;
            acc_addr = addr; acc_wdata = wdata; acc_cyc = i;
            break;
         end
      end
      if (!acc_ok) begin
         n_chk++; n_err++;
         $display("FAIL %s: no bus access within %0d cycles", name, budget);
      end
   endtask

   task automatic echo_drain(input logic [7:0] b);
`ifdef UART_ECHO_EN
      wait_acc("echo_wr", 30);
      chk("echo_wr_strobe", acc_wr, 1);
      chk("echo_wr_addr", acc_addr, A_TXD);
      chk("echo_wr_data", acc_wdata, {24'b0, b});
      chk("echo_rx_valid", rx_valid, 1);
      tx_set_cnt++;
      wait_acc("echo_ack", 30);
      chk("echo_ack_addr", acc_addr, A_TXD);
      @(negedge clk);
      chk("echo_busy_clr", tx_busy, 0);
`else
      chk("no_echo_busy", tx_busy, 0);
      chk("no_echo_ready", tx_ready, 1);
      chk("no_echo_byte", {24'b0, b}, {24'b0, rx_data});
`endif
   endtask

   typedef struct {
      logic        tx_valid;
      logic [7:0]  tx_data;
      logic        rd;
      logic        wr;
      logic        chk_addr;
      logic [31:0] addr;
      logic        chk_wdata;
      logic [31:0] wdata;
      logic        tx_ready;
      logic        rx_valid;
      logic        tx_busy;
   } vec_t;

   vec_t tbl[10];
   int   t0, tcyc;

   initial begin
      tbl[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h0,   1'b1, 32'h0,  1'b1, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, A_CON,   1'b1, 32'h3,  1'b1, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b1, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, A_CON,   1'b0, 32'h0,  1'b0, 1'b0, 1'b0};
      tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 1'b0, 1'b0};
      tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, A_TXD,   1'b1, 32'hA5, 1'b0, 1'b0, 1'b0};
      tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b1, 1'b0, 1'b1};

      reset = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state, INIT write, POLL_GAP idle cycles, first poll, first TXD write.
      for (int k = 0; k < 10; k++) begin
         tx_valid = tbl[k].tx_valid;
         tx_data  = tbl[k].tx_data;
         if (k > 0) @(negedge clk);
         chk($sformatf("vec%0d_rd", k), rd, tbl[k].rd);
         chk($sformatf("vec%0d_wr", k), wr, tbl[k].wr);
         if (tbl[k].chk_addr)  chk($sformatf("vec%0d_addr", k), addr, tbl[k].addr);
         if (tbl[k].chk_wdata) chk($sformatf("vec%0d_wdata", k), wdata, tbl[k].wdata);
         chk($sformatf("vec%0d_tx_ready", k), tx_ready, tbl[k].tx_ready);
         chk($sformatf("vec%0d_rx_valid", k), rx_valid, tbl[k].rx_valid);
         chk($sformatf("vec%0d_tx_busy", k), tx_busy, tbl[k].tx_busy);
         chk($sformatf("vec%0d_tx_timeout", k), tx_timeout, 0);
         if (k == 0) reset = 1'b1;
      end

      // Transmit completion: CON[2] set, one TXD read acknowledges it.
      tx_set_cnt++;
      wait_acc("tx_ack", 30);
      chk("tx_ack_rd", acc_rd, 1);
      chk("tx_ack_addr", acc_addr, A_TXD);
      @(negedge clk);
      chk("tx_ack_busy", tx_busy, 0);
      chk("tx_ack_con2", con2, 0);

      // Receive 0x3C with the client stalled.
      rxd_val = 8'h3C;
      rx_set_cnt++;
      wait_acc("rx_rd", 30);
      chk("rx_rd_rd", acc_rd, 1);
      chk("rx_rd_addr", acc_addr, A_RXD);
      chk_rng("rx_latency", acc_cyc + 1, 1, POLL_GAP + 4);
      @(negedge clk);
      chk("rx_valid_3c", rx_valid, 1);
      chk("rx_data_3c", rx_data, 8'h3C);
      echo_drain(8'h3C);

      // A second byte arrives while rx_valid is held: it must stay in the peripheral.
      rxd_val = 8'h77;
      rx_set_cnt++;
      t0 = rx_rd_cnt;
      repeat (40) @(negedge clk);
      chk("rx_hold_no_read", rx_rd_cnt, t0);
      chk("rx_hold_valid", rx_valid, 1);
      chk("rx_hold_data", rx_data, 8'h3C);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      chk("rx_accept_clr", rx_valid, 0);
      wait_acc("rx_rd2", 30);
      chk("rx_rd2_addr", acc_addr, A_RXD);
      @(negedge clk);
      chk("rx_data_77", rx_data, 8'h77);
      echo_drain(8'h77);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;

      // RX and a pending TX byte seen in the same poll: RXD read wins.
      rxd_val = 8'h99;
      rx_set_cnt++;
      tx_data = 8'h11; tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      wait_acc("prio_first", 30);
      chk("prio_first_rd", acc_rd, 1);
      chk("prio_first_addr", acc_addr, A_RXD);
      wait_acc("prio_second", 30);
      chk("prio_second_wr", acc_wr, 1);
      chk("prio_second_addr", acc_addr, A_TXD);
      chk("prio_second_data", acc_wdata, 32'h11);
      chk("prio_rx_data", rx_data, 8'h99);
      @(negedge clk);
      chk("prio_busy", tx_busy, 1);
      rx_ready = 1'b1;
      tx_set_cnt++;
      @(negedge clk);
      rx_ready = 1'b0;
      wait_acc("prio_ack", 30);
      chk("prio_ack_addr", acc_addr, A_TXD);
      @(negedge clk);
      chk("prio_ack_busy", tx_busy, 0);

      // Held byte to write latency, then a transmit that never completes.
      tx_data = 8'h5A; tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      wait_acc("tmo_wr", 30);
      chk_rng("tx_latency", acc_cyc, 1, POLL_GAP + 3);
      chk("tmo_wr_data", acc_wdata, 32'h5A);
      tcyc = 0;
      for (int i = 1; i <= 300; i++) begin
         @(negedge clk);
         if (i == 50) chk("tmo_busy_mid", tx_busy, 1);
         if (tx_timeout) begin
            tcyc = i;
            break;
         end
      end
      chk_rng("tmo_cycles", tcyc, 99, 102);
      chk("tmo_busy_clr", tx_busy, 0);
      t0 = poll_cnt;
      repeat (30) @(negedge clk);
      chk_rng("tmo_polls", poll_cnt - t0, 4, 6);
      chk("tmo_sticky", tx_timeout, 1);
      chk("no_dual_strobe", both_cnt, 0);

      // Asynchronous reset in the middle of a poll strobe.
      tcyc = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (rd) begin
            tcyc = i;
            break;
         end
      end
      chk_rng("arst_found_poll", tcyc, 1, 20);
      reset = 1'b0;
      #1;
      chk("arst_rd", rd, 0);
      chk("arst_wr", wr, 0);
      chk("arst_timeout", tx_timeout, 0);
      chk("arst_tx_ready", tx_ready, 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("arst_init_wr", wr, 1);
      chk("arst_init_addr", addr, A_CON);
      chk("arst_init_wdata", wdata, 32'h3);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
